// File: rtl/dmem_pkg.sv
// Shared constants, request payload and lane-merge helper for the data-side memory responder.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1FD0_0000;

    // Timer register byte offsets inside the MMIO window
    localparam logic [15:0] TMR_COUNT_OFF   = 16'h0000;
    localparam logic [15:0] TMR_COMPARE_OFF = 16'h0004;
    localparam logic [15:0] TMR_CTRL_OFF    = 16'h0008;

    // CTRL register bit positions
    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_PEND   = 1;
    localparam int unsigned CTRL_RELOAD = 2;

    // Word offset width inside the 64 KiB window (byte offset bits [15:2])
    localparam int unsigned OFF_W = 14;

    // Access payload handed to the timer: word offset, lane strobes, store data
    typedef struct packed {
        logic [OFF_W-1:0] off;
        logic [3:0]       be;
        logic [31:0]      data;
    } tmr_req_t;

    // Replace the enabled byte lanes of old_val with the matching lanes of new_val
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_bus_if.sv
// Core data-port bundle: request from the memory stage, load data and interrupts back.
interface dmem_bus_if;
    logic        dce;
    logic [31:0] daddr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] dm;
    logic [5:0]  irq;

    modport master (output dce, daddr, we, din, input dm, irq);
    modport slave  (input dce, daddr, we, din, output dm, irq);
endinterface

// File: rtl/dmem_timer.sv
// Memory-mapped timer: COUNT/COMPARE/CTRL, compare match with optional reload, registered irq.
module dmem_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  tmr_req_t    req,
    output logic [31:0] rdata_c,
    output logic        irq5
);

    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        en_q;
    logic        pend_q;
    logic        reload_q;

    logic wr_count_c;
    logic wr_compare_c;
    logic wr_ctrl_c;
    logic match_c;

    // Register selects; CTRL only reacts to lane 0
    assign wr_count_c   = wr_en && (req.off == TMR_COUNT_OFF[15:2]);
    assign wr_compare_c = wr_en && (req.off == TMR_COMPARE_OFF[15:2]);
    assign wr_ctrl_c    = wr_en && (req.off == TMR_CTRL_OFF[15:2]) && req.be[0];
    assign match_c      = en_q && (count_q == compare_q);

    // Timer state; software COUNT write beats increment, match set beats PEND clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= '1;
            en_q      <= 1'b0;
            pend_q    <= 1'b0;
            reload_q  <= 1'b0;
            irq5      <= 1'b0;
        end else begin
            if (wr_count_c) begin
                count_q <= merge_lanes(count_q, req.data, req.be);
            end else if (en_q) begin
                count_q <= (match_c && reload_q) ? 32'd0 : count_q + 32'd1;
            end
            if (wr_compare_c) begin
                compare_q <= merge_lanes(compare_q, req.data, req.be);
            end
            if (wr_ctrl_c) begin
                en_q     <= req.data[CTRL_EN];
                reload_q <= req.data[CTRL_RELOAD];
            end
            if (match_c) begin
                pend_q <= 1'b1;
            end else if (wr_ctrl_c && req.data[CTRL_PEND]) begin
                pend_q <= 1'b0;
            end
            irq5 <= pend_q && en_q;
        end
    end

    // Register read mux; unmapped offsets return 0
    always_comb begin
        rdata_c = '0;
        if (req.off == TMR_COUNT_OFF[15:2]) begin
            rdata_c = count_q;
        end else if (req.off == TMR_COMPARE_OFF[15:2]) begin
            rdata_c = compare_q;
        end else if (req.off == TMR_CTRL_OFF[15:2]) begin
            rdata_c[CTRL_EN]     = en_q;
            rdata_c[CTRL_PEND]   = pend_q;
            rdata_c[CTRL_RELOAD] = reload_q;
        end
    end

endmodule

// File: rtl/dmem_bus.sv
// Data-side memory responder: byte-writable RAM plus MMIO window, 1-cycle registered load data.
// Optional timer built when DMEM_TIMER_EN is defined; otherwise MMIO reads 0 and irq is 0.
module dmem_bus
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
)
(
    input  logic       clk,
    input  logic       rst_n,
    dmem_bus_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    logic             mmio_hit_c;
    logic [IDX_W-1:0] idx_c;
    logic             ram_wr_c;
    logic [31:0]      mmio_rdata_c;
    logic             unused_addr;

    // Address decode; RAM aliases on the ignored upper bits
    assign mmio_hit_c  = (bus.daddr[31:16] == MMIO_BASE[31:16]);
    assign idx_c       = bus.daddr[IDX_W+1:2];
    assign ram_wr_c    = bus.dce && rst_n && !mmio_hit_c && (bus.we != 4'h0);
    assign unused_addr = ^bus.daddr;

    // Byte-lane RAM write; contents are not reset
    always_ff @(posedge clk) begin
        if (ram_wr_c) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.we[i]) mem[idx_c][8*i +: 8] <= bus.din[8*i +: 8];
            end
        end
    end

`ifdef DMEM_TIMER_EN
    tmr_req_t tmr_req_c;
    logic     tmr_wr_c;
    logic     irq5;

    // Pack the access for the timer
    always_comb begin
        tmr_req_c      = '0;
        tmr_req_c.off  = bus.daddr[15:2];
        tmr_req_c.be   = bus.we;
        tmr_req_c.data = bus.din;
    end

    assign tmr_wr_c = bus.dce && mmio_hit_c && (bus.we != 4'h0);

    dmem_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tmr_wr_c),
        .req     (tmr_req_c),
        .rdata_c (mmio_rdata_c),
        .irq5    (irq5)
    );

    assign bus.irq = {irq5, 5'b0};
`else
    assign mmio_rdata_c = '0;
    assign bus.irq      = '0;
`endif

    // Registered load data; old data returned when the same access writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.dm <= '0;
        end else if (bus.dce) begin
            bus.dm <= mmio_hit_c ? mmio_rdata_c : mem[idx_c];
        end
    end

endmodule

// File: tb/tb_dmem_bus.sv
// Self-checking bench for dmem_bus: load scoreboard plus direct irq/dm checks.
// Exercises the timer when DMEM_TIMER_EN is defined, the disabled MMIO window otherwise.
module tb_dmem_bus;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] MB    = 32'h1FD0_0000;

    logic clk;
    logic rst_n;

    dmem_bus_if bus ();

    dmem_bus #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic        rd_hit;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle; loads outside reset queue their expected data
    task automatic cyc(input logic d, input logic [31:0] a, input logic [3:0] w,
                       input logic [31:0] dd, input string tag, input logic [31:0] exp);
        bus.dce   = d;
        bus.daddr = a;
        bus.we    = w;
        bus.din   = dd;
        if (d && w == 4'h0 && rst_n) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] dd);
        cyc(1'b1, a, w, dd, "", 32'd0);
    endtask

    task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
        cyc(1'b1, a, 4'h0, 32'd0, tag, exp);
    endtask

    task automatic idle();
        cyc(1'b0, 32'd0, 4'h0, 32'd0, "", 32'd0);
    endtask

    // Load monitor: compare dm one cycle after each accepted load
    always @(posedge clk) begin
        rd_hit = bus.dce && (bus.we == 4'h0) && rst_n;
        #1;
        if (rd_hit) begin
            if (exp_q.size() == 0) check("sb_pop_empty", 32'(exp_q.size()), 32'd1);
            else check(tag_q.pop_front(), bus.dm, exp_q.pop_front());
        end
    end

    initial begin
        rst_n     = 1'b0;
        bus.dce   = 1'b0;
        bus.daddr = '0;
        bus.we    = '0;
        bus.din   = '0;
        idle();
        idle();
        check("rst_dm", bus.dm, 32'd0);
        check("rst_irq", 32'(bus.irq), 32'd0);
        rst_n = 1'b1;

        // RAM: full word, lanes, alias, read-during-write, hold
        wr(32'h100, 4'hF, 32'hDEAD_BEEF);
        rd(32'h100, "word_rd", 32'hDEAD_BEEF);
        wr(32'h200, 4'hF, 32'hAABB_CCDD);
        wr(32'h200, 4'b0101, 32'h1122_3344);
        rd(32'h200, "byte_lanes", 32'hAA22_CC44);
        wr(32'h10, 4'hF, 32'h5);
        rd(DEPTH * 4 + 32'h10, "alias", 32'h5);
        wr(32'h100, 4'hF, 32'h0BAD_F00D);
        check("rd_during_wr", bus.dm, 32'hDEAD_BEEF);
        rd(32'h100, "new_data", 32'h0BAD_F00D);
        idle();
        check("dm_hold", bus.dm, 32'h0BAD_F00D);

        // MMIO window never aliases RAM
        wr(MB + 32'h100, 4'hF, 32'h0);
        rd(32'h100, "mmio_no_alias", 32'h0BAD_F00D);
        rd(MB + 32'h100, "mmio_unmapped", 32'h0);

`ifdef DMEM_TIMER_EN
        rd(MB + 32'h4, "cmp_rst", 32'hFFFF_FFFF);
        rd(MB + 32'h8, "ctrl_rst", 32'h0);
        rd(MB + 32'h0, "count_rst", 32'h0);
        wr(MB + 32'h4, 4'hF, 32'd10);
        wr(MB + 32'h8, 4'h1, 32'h5);
        for (int i = 1; i <= 12; i++) begin
            if (i == 12) rd(MB + 32'h0, "count_reload", 32'h0);
            else idle();
            if (i == 11) check("irq_pre", 32'(bus.irq), 32'h0);
            if (i == 12) check("irq_rise", 32'(bus.irq), 32'h20);
        end
        wr(MB + 32'h8, 4'h1, 32'h7);
        check("irq_hold", 32'(bus.irq), 32'h20);
        idle();
        check("irq_fall", 32'(bus.irq), 32'h0);

        // COUNT write while running, then clear PEND in the match cycle
        wr(MB + 32'h0, 4'hF, 32'h1234);
        rd(MB + 32'h0, "count_wr", 32'h1234);
        wr(MB + 32'h4, 4'hF, 32'h1238);
        idle();
        idle();
        wr(MB + 32'h8, 4'h1, 32'h7);
        rd(MB + 32'h8, "pend_set_wins", 32'h7);
        check("irq_set_wins", 32'(bus.irq), 32'h20);

        // EN=0 masks irq but keeps PEND
        wr(MB + 32'h8, 4'h1, 32'h4);
        rd(MB + 32'h8, "pend_kept", 32'h6);
        check("irq_masked", 32'(bus.irq), 32'h0);
        wr(MB + 32'h8, 4'h1, 32'h1);
        idle();
        check("irq_unmask", 32'(bus.irq), 32'h20);

        // Mid-count reset drops the MMIO write in that cycle
        rst_n = 1'b0;
        wr(MB + 32'h4, 4'hF, 32'h55);
        check("mid_rst_irq", 32'(bus.irq), 32'h0);
        rst_n = 1'b1;
        rd(MB + 32'h0, "mid_rst_count", 32'h0);
        rd(MB + 32'h4, "mid_rst_cmp", 32'hFFFF_FFFF);
        rd(MB + 32'h8, "mid_rst_ctrl", 32'h0);
`else
        rd(MB + 32'h4, "mmio_off_cmp", 32'h0);
        wr(MB + 32'h0, 4'hF, 32'h1234);
        wr(MB + 32'h8, 4'h1, 32'h5);
        repeat (14) idle();
        check("irq_off", 32'(bus.irq), 32'h0);
        rd(MB + 32'h0, "mmio_off_count", 32'h0);
`endif

        // Reset drops a RAM write and clears dm
        rd(32'h100, "pre_rst_rd", 32'h0BAD_F00D);
        rst_n = 1'b0;
        wr(32'h100, 4'hF, 32'hFFFF_FFFF);
        check("rst_dm_clear", bus.dm, 32'd0);
        check("rst_irq_clear", 32'(bus.irq), 32'd0);
        rst_n = 1'b1;
        rd(32'h100, "rst_ram_drop", 32'h0BAD_F00D);
        idle();
        idle();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_bus.md
# dmem_bus

Data-side memory responder for the pipeline's data port: accepts the core's `dce`/`daddr`/`we`/`din` requests and returns load data on `dm` one cycle later, as the write-back stage expects. The block holds a byte-writable on-chip RAM and a small memory-mapped timer. The timer drives the core's 6-bit interrupt input. It sits beside the core in the SoC top, on the opposite end of the data interface from the memory stage.

## Interface
- `DEPTH_WORDS`, 1024, RAM depth in 32-bit words; power of two.
- `MMIO_BASE`, 32'h1FD0_0000, base of the 64 KiB MMIO window; compared on `daddr[31:16]`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `dce` in 1: access enable; no state changes and no `dm` update when low.
- `daddr` in 32: byte address; bits [1:0] ignored.
- `we` in 4: byte-lane write strobes; `we[3]` covers `din[31:24]`, `we[0]` covers `din[7:0]`. A value of 0 means read.
- `din` in 32: store data, already lane-aligned by the core.
- `dm` out 32: registered load data.
- `irq` out 6: connects to the core's `int`. Bit 5 is the timer; bits 4:0 are always 0.

## Operation
- Decode:
  - MMIO hit when `daddr[31:16] == MMIO_BASE[31:16]`.
  - Otherwise RAM, with index `daddr[log2(DEPTH_WORDS)+1:2]`. Higher bits are ignored, so the RAM aliases.
- RAM write:
  - On `dce & |we`, each enabled byte lane is written at the clock edge.
  - Disabled lanes are unchanged.
- RAM read:
  - On `dce`, `dm` captures the word at the index at the clock edge.
  - When `we` is nonzero in the same access, `dm` returns the old (pre-write) data.
- MMIO timer registers (offset = `daddr[15:0]`):
  - 0x0 COUNT: read/write.
  - 0x4 COMPARE: read/write.
  - 0x8 CTRL: bit0 EN, bit1 PEND (write 1 to clear, read returns the flag), bit2 RELOAD, other bits read 0.
  - Byte strobes are honoured on COUNT and COMPARE. On CTRL, only lane 0 matters.
  - Unmapped offsets read 0; writes to them are ignored.
- COUNT:
  - When EN=1, COUNT increments by 1 per cycle and wraps from 0xFFFF_FFFF to 0.
  - A software write to COUNT has priority over the increment in the same cycle.
- Match: in a cycle with EN=1 and COUNT == COMPARE:
  - PEND is set at the next edge.
  - If RELOAD=1, COUNT becomes 0 at that edge instead of COUNT+1.
- PEND conflicts: if a match and a write-1-to-clear of PEND occur in the same cycle, set wins.
- `irq[5] = PEND & EN`, registered. EN=0 masks the output but keeps PEND.

## Timing
- Reset values: `dm`=0, `irq`=0, COUNT=0, COMPARE=0xFFFF_FFFF, CTRL=0. RAM contents are not reset.
- Reset asserted mid-operation:
  - Registers return to their reset values at the next edge.
  - A write presented in that cycle is dropped for both RAM and MMIO.
- Load latency: exactly 1 cycle. `dm` holds its value until the next `dce` cycle.
- Back-to-back accesses are accepted every cycle. There is no stall and no backpressure.
- `irq[5]` goes high 2 cycles after the cycle in which COUNT == COMPARE: PEND is set at edge 1, and the irq register follows at edge 2.
- A read of COUNT returns the value before this cycle's increment.

## Configuration
- `DMEM_TIMER_EN` defined:
  - Timer registers and `irq[5]` behave as described above.
- `DMEM_TIMER_EN` undefined:
  - The timer logic is not built.
  - The MMIO window is still decoded, so it never aliases RAM.
  - All MMIO reads return 0 and all MMIO writes are ignored.
  - `irq` is constant 0.

## Structure
- Package `dmem_pkg` holds:
  - MMIO offsets (`TMR_COUNT_OFF`, `TMR_COMPARE_OFF`, `TMR_CTRL_OFF`).
  - CTRL bit indices (`CTRL_EN`, `CTRL_PEND`, `CTRL_RELOAD`).
  - The default `MMIO_BASE`.
- One sub-module, `dmem_timer`, contains COUNT/COMPARE/CTRL, the match logic and the irq register.
  - It takes a decoded write strobe, offset, lane strobes and `din`.
  - It returns the read data and `irq5`.
  - It is instantiated only under `DMEM_TIMER_EN`.
- The RAM array and the read mux live in `dmem_bus`.

## Test plan
- Full-word store then load:
  - Write 0xDEAD_BEEF at 0x100 (`we`=4'hF), then read 0x100.
  - Required: `dm`=0xDEAD_BEEF one cycle after the read.
- Byte lanes:
  - Store 0x1122_3344 with `we`=4'b0101 over a word holding 0xAABB_CCDD.
  - Required: a subsequent load returns 0xAA22_CC44.
- Alias:
  - Store 0x5 at address 0x10, then load from `DEPTH_WORDS*4 + 0x10`.
  - Required: returns 0x5.
- Timer match and clear:
  - Write COMPARE=10 and CTRL=0x5 (EN and RELOAD).
  - Required: `irq[5]` rises 12 cycles after the CTRL write (COUNT reaches 10 ten cycles after the write, plus 2-cycle irq latency), and COUNT reads 0 after the match.
  - Write CTRL=0x7 (bit1 clears PEND); `irq[5]` falls two cycles later.
- Simultaneous events:
  - Write-1-to-clear PEND in the exact match cycle. Required: PEND stays 1.
  - Write COUNT=0x1234 while EN=1. Required: COUNT reads 0x1234 on the next cycle's read.
- Reset and config:
  - Assert `rst_n`=0 for one cycle mid-count. Required: COUNT=0, `irq`=0, `dm`=0.
  - With `DMEM_TIMER_EN` undefined, a read of MMIO_BASE+0x4 returns 0 and `irq` stays 0.
